// File: rtl/riscv_memory_write_buffer_pkg.sv
// Shared types and constants for the data-cache write buffer.
package riscv_memory_write_buffer_pkg;

   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned TAG_WIDTH  = 30;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] address;
      logic [WORD_WIDTH-1:0] data;
   } wb_entry_t;

   // Word index of a byte address; byte-offset bits never take part in a match.
   function automatic logic [TAG_WIDTH-1:0] word_tag(input logic [WORD_WIDTH-1:0] address);
      return TAG_WIDTH'(address >> (WORD_WIDTH - TAG_WIDTH));
   endfunction

endpackage

// File: rtl/riscv_write_fifo.sv
// Write-buffer storage: circular FIFO plus a youngest-match search port for forwarding.
module riscv_write_fifo
   import riscv_memory_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  wb_entry_t               push_entry,
   input  logic                    pop,
   output wb_entry_t               head_entry,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   input  logic [WORD_WIDTH-1:0]   search_address,
   output logic                    search_hit,
   output logic [WORD_WIDTH-1:0]   search_data
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   wb_entry_t             mem [DEPTH];
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH-1:0]  wr_ptr;

   assign full       = (count == CNT_WIDTH'(DEPTH));
   assign empty      = (count == '0);
   assign head_entry = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
   end

   // When full, a simultaneous pop makes wr_ptr equal to the retiring head slot.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // Scan oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      search_hit  = 1'b0;
      search_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_WIDTH'(i) < count &&
             word_tag(mem[rd_ptr + PTR_WIDTH'(i)].address) == word_tag(search_address)) begin
            search_hit  = 1'b1;
            search_data = mem[rd_ptr + PTR_WIDTH'(i)].data;
         end
      end
   end

endmodule

// File: rtl/riscv_memory_write_buffer.sv
// Write buffer between the data cache and RAM: queued writes, read-miss service, store forwarding.
module riscv_memory_write_buffer
   import riscv_memory_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] cache_address,
   input  logic                  cache_read,
   input  logic                  cache_write,
   input  logic [WORD_WIDTH-1:0] cache_write_data,
   output logic [WORD_WIDTH-1:0] cache_read_data,
   output logic                  cache_ready,
   output logic [WORD_WIDTH-1:0] cache_address_ready,
   output logic [WORD_WIDTH-1:0] ram_address,
   output logic                  ram_read,
   output logic                  ram_write,
   output logic [WORD_WIDTH-1:0] ram_write_data,
   input  logic [WORD_WIDTH-1:0] ram_read_data,
   input  logic                  ram_ack,
   output logic                  buffer_empty
);

   localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

   wb_state_e             state;
   wb_entry_t             head_entry;
   wb_entry_t             push_entry;
   logic [CNT_WIDTH-1:0]  count;
   logic [CNT_WIDTH-1:0]  count_next;
   logic                  full;
   logic                  empty;
   logic                  search_hit;
   logic [WORD_WIDTH-1:0] search_data;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  read_accept;
   logic                  forward;
   logic                  read_miss;
   logic                  ram_read_done;
   logic                  read_valid;
   logic [WORD_WIDTH-1:0] read_address;
   logic [WORD_WIDTH-1:0] read_data;
   logic [WORD_WIDTH-1:0] req_address;
   logic                  read_lock;
   logic                  ready_is_read;
   logic                  pending_valid;
   logic [WORD_WIDTH-1:0] pending_address;
   logic [WORD_WIDTH-1:0] pending_data;

   assign push_entry    = '{address: cache_address, data: cache_write_data};
   assign fifo_pop      = (state == WRITE_WAIT) && ram_ack;
   assign fifo_push     = cache_write && (!full || fifo_pop);
   assign count_next    = count + CNT_WIDTH'(fifo_push) - CNT_WIDTH'(fifo_pop);

   // A held read is taken once; read_lock blocks re-acceptance until its response has been shown.
   assign read_accept   = cache_read && !read_lock && (search_hit || state == IDLE);
   assign forward       = read_accept && search_hit;
   assign read_miss     = read_accept && !search_hit;
   assign ram_read_done = (state == READ_WAIT) && ram_ack;
   assign read_valid    = forward || ram_read_done;
   assign read_address  = forward ? cache_address : req_address;
   assign read_data     = forward ? search_data : ram_read_data;

   riscv_write_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .push           (fifo_push),
      .push_entry     (push_entry),
      .pop            (fifo_pop),
      .head_entry     (head_entry),
      .count          (count),
      .full           (full),
      .empty          (empty),
      .search_address (cache_address),
      .search_hit     (search_hit),
      .search_data    (search_data)
   );

   // RAM-side sequencer: read misses take priority over draining the FIFO head.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         ram_read       <= 1'b0;
         ram_write      <= 1'b0;
         ram_address    <= '0;
         ram_write_data <= '0;
         req_address    <= '0;
         buffer_empty   <= 1'b1;
      end else begin
         buffer_empty <= (count_next == '0);
         case (state)
            IDLE: begin
               if (read_miss) begin
                  state       <= READ_WAIT;
                  ram_read    <= 1'b1;
                  ram_address <= cache_address;
                  req_address <= cache_address;
               end else if (!empty) begin
                  state          <= WRITE_WAIT;
                  ram_write      <= 1'b1;
                  ram_address    <= head_entry.address;
                  ram_write_data <= head_entry.data;
               end
            end
            READ_WAIT: begin
               if (ram_ack) begin
                  state    <= IDLE;
                  ram_read <= 1'b0;
               end
            end
            WRITE_WAIT: begin
               if (ram_ack) begin
                  state     <= IDLE;
                  ram_write <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response port: write acks win; a colliding read response waits one slot in pending.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cache_ready         <= 1'b0;
         cache_address_ready <= '0;
         cache_read_data     <= '0;
         ready_is_read       <= 1'b0;
         pending_valid       <= 1'b0;
         pending_address     <= '0;
         pending_data        <= '0;
         read_lock           <= 1'b0;
      end else begin
         if (fifo_push) begin
            cache_ready         <= 1'b1;
            cache_address_ready <= cache_address;
            cache_read_data     <= cache_write_data;
            ready_is_read       <= 1'b0;
            if (read_valid) begin
               pending_valid   <= 1'b1;
               pending_address <= read_address;
               pending_data    <= read_data;
            end
         end else if (pending_valid) begin
            cache_ready         <= 1'b1;
            cache_address_ready <= pending_address;
            cache_read_data     <= pending_data;
            ready_is_read       <= 1'b1;
            pending_valid       <= 1'b0;
         end else if (read_valid) begin
            cache_ready         <= 1'b1;
            cache_address_ready <= read_address;
            cache_read_data     <= read_data;
            ready_is_read       <= 1'b1;
         end else begin
            cache_ready   <= 1'b0;
            ready_is_read <= 1'b0;
         end

         if (read_accept)
            read_lock <= 1'b1;
         else if (cache_ready && ready_is_read)
            read_lock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_memory_write_buffer.sv
// Scoreboard bench for the write buffer with a behavioural cache driver and RAM model.
module tb_riscv_memory_write_buffer;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } resp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cache_address = '0;
   logic        cache_read = 1'b0;
   logic        cache_write = 1'b0;
   logic [31:0] cache_write_data = '0;
   logic [31:0] cache_read_data;
   logic        cache_ready;
   logic [31:0] cache_address_ready;
   logic [31:0] ram_address;
   logic        ram_read;
   logic        ram_write;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data = '0;
   logic        ram_ack = 1'b0;
   logic        buffer_empty;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   resp_t       exp_q[$];
   resp_t       ram_exp_q[$];
   logic [31:0] model_mem[logic [31:0]];
   logic [31:0] ram_mem[logic [31:0]];
   int          ram_delay_fixed = 0;
   int          ram_reads = 0;
   int          ram_writes = 0;
   int unsigned last_read_ack_cyc = 0;

   riscv_memory_write_buffer #(.DEPTH(4)) dut (
      .clock               (clock),
      .reset               (reset),
      .cache_address       (cache_address),
      .cache_read          (cache_read),
      .cache_write         (cache_write),
      .cache_write_data    (cache_write_data),
      .cache_read_data     (cache_read_data),
      .cache_ready         (cache_ready),
      .cache_address_ready (cache_address_ready),
      .ram_address         (ram_address),
      .ram_read            (ram_read),
      .ram_write           (ram_write),
      .ram_write_data      (ram_write_data),
      .ram_read_data       (ram_read_data),
      .ram_ack             (ram_ack),
      .buffer_empty        (buffer_empty)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] ram_default(input logic [31:0] a);
      return ~a ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Monitor: every response strobe must match the oldest outstanding expectation.
   resp_t mon_e;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (reset && cache_ready) begin
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_response");
            end else begin
               mon_e = exp_q.pop_front();
               check("resp_address", cache_address_ready, mon_e.a);
               check("resp_data", cache_read_data, mon_e.d);
            end
         end
      end
   end

   // RAM model: checks write order at request start, acks after a programmable delay.
   logic [31:0] ram_a;
   logic [31:0] ram_wd;
   logic        ram_is_wr;
   int          ram_d;
   resp_t       ram_e;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (reset && (ram_read || ram_write)) begin
            ram_a     = ram_address;
            ram_wd    = ram_write_data;
            ram_is_wr = ram_write;
            check("ram_rw_exclusive", 32'(ram_read & ram_write), 32'd0);
            if (ram_is_wr) begin
               ram_writes++;
               if (ram_exp_q.size() == 0) begin
                  timeout_fail("ram_unexpected_write");
               end else begin
                  ram_e = ram_exp_q.pop_front();
                  check("ram_write_address", ram_a, ram_e.a);
                  check("ram_write_data", ram_wd, ram_e.d);
               end
            end else begin
               ram_reads++;
            end
            ram_d = (ram_delay_fixed != 0) ? ram_delay_fixed : int'($urandom_range(1, 4));
            repeat (ram_d) @(posedge clock);
            #1;
            if (ram_is_wr) begin
               ram_mem[ram_a] = ram_wd;
            end else begin
               ram_read_data     = ram_mem.exists(ram_a) ? ram_mem[ram_a] : ram_default(ram_a);
               last_read_ack_cyc = cyc;
            end
            ram_ack = 1'b1;
            @(posedge clock);
            #1;
            ram_ack       = 1'b0;
            ram_read_data = $urandom;
         end
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
      resp_t e;
      bit    ok;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
      ram_exp_q.push_back(e);
      model_mem[a]     = d;
      cache_address    = a;
      cache_write_data = d;
      cache_write      = 1'b1;
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
         ok = cache_ready && (cache_address_ready == a);
      end
      cache_write = 1'b0;
      if (!ok) timeout_fail("write_ack");
   endtask

   task automatic do_read(input logic [31:0] a, output int unsigned resp_cyc, output int lat);
      resp_t e;
      bit    ok;
      e.a = a;
      e.d = model_mem.exists(a) ? model_mem[a] : ram_default(a);
      exp_q.push_back(e);
      cache_address = a;
      cache_read    = 1'b1;
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
         ok = cache_ready && (cache_address_ready == a);
      end
      cache_read = 1'b0;
      resp_cyc   = cyc;
      if (!ok) timeout_fail("read_response");
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (!buffer_empty && n < 1000) begin
         @(posedge clock);
         #1;
         n++;
      end
      check(name, 32'(buffer_empty), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cache_ready"}, 32'(cache_ready), 32'd0);
      check({tag, "_cache_address_ready"}, cache_address_ready, 32'd0);
      check({tag, "_cache_read_data"}, cache_read_data, 32'd0);
      check({tag, "_ram_read"}, 32'(ram_read), 32'd0);
      check({tag, "_ram_write"}, 32'(ram_write), 32'd0);
      check({tag, "_ram_address"}, ram_address, 32'd0);
      check({tag, "_ram_write_data"}, ram_write_data, 32'd0);
      check({tag, "_buffer_empty"}, 32'(buffer_empty), 32'd1);
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int          lat;
   int          lats[5];
   int unsigned rc;
   int          snap;
   int          n;
   logic [31:0] old_val;
   resp_t       e;

   initial begin
      ram_mem[32'h300]   = 32'hDEAD_BEEF;
      model_mem[32'h300] = 32'hDEAD_BEEF;

      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      @(negedge clock);
      reset = 1'b1;

      // Single write on an empty buffer
      do_write(32'h100, 32'hAAAA_0001, lat);
      check("first_write_latency", 32'(lat), 32'd1);
      check("not_empty_after_write", 32'(buffer_empty), 32'd0);
      wait_empty("drain_single");
      check("single_ram_write_count", 32'(ram_writes), 32'd1);

      // Five back-to-back writes into a four-entry buffer with slow RAM
      ram_delay_fixed = 10;
      for (int k = 0; k < 5; k++)
         do_write(32'h600 + 32'(4 * k), 32'h6000_0000 + 32'(k), lats[k]);
      for (int k = 0; k < 4; k++)
         check("burst_write_latency", 32'(lats[k]), 32'd1);
      check("full_write_stalled", 32'(lats[4] > 1), 32'd1);
      wait_empty("drain_burst");

      // Duplicate-address writes, youngest forwarded without touching RAM
      do_write(32'h200, 32'd1, lat);
      do_write(32'h200, 32'd2, lat);
      snap = ram_reads;
      do_read(32'h200, rc, lat);
      check("forward_latency", 32'(lat), 32'd1);
      check("forward_no_ram_read", 32'(ram_reads), 32'(snap));
      wait_empty("drain_forward");

      // Read miss blocks draining of a freshly queued write
      ram_delay_fixed = 3;
      do_write(32'h500, 32'h5555_0000, lat);
      snap = ram_writes;
      do_read(32'h300, rc, lat);
      check("miss_response_after_ack", rc, last_read_ack_cyc + 1);
      check("miss_blocks_drain", 32'(ram_writes), 32'(snap));
      wait_empty("drain_miss");

      // Forwarded read and write ack in the same cycle
      ram_delay_fixed = 10;
      do_write(32'h400, 32'h4444_0001, lat);
      old_val = model_mem[32'h400];
      e.a = 32'h400; e.d = 32'h4444_0002;
      exp_q.push_back(e);
      ram_exp_q.push_back(e);
      e.a = 32'h400; e.d = old_val;
      exp_q.push_back(e);
      model_mem[32'h400] = 32'h4444_0002;
      snap = ram_reads;
      cache_address    = 32'h400;
      cache_write_data = 32'h4444_0002;
      cache_write      = 1'b1;
      cache_read       = 1'b1;
      @(posedge clock);
      #1;
      cache_write = 1'b0;
      check("collision_ack_ready", 32'(cache_ready), 32'd1);
      check("collision_ack_data", cache_read_data, 32'h4444_0002);
      @(posedge clock);
      #1;
      cache_read = 1'b0;
      check("collision_read_ready", 32'(cache_ready), 32'd1);
      check("collision_read_data", cache_read_data, old_val);
      check("collision_no_ram_read", 32'(ram_reads), 32'(snap));
      wait_empty("drain_collision");

      // Reset while a RAM write is outstanding
      do_write(32'h700, 32'h7000_0001, lat);
      do_write(32'h704, 32'h7000_0002, lat);
      n = 0;
      while (!ram_write && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (!ram_write) timeout_fail("reset_test_ram_write");
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      check("midreset_no_pending_resp", 32'(exp_q.size()), 32'd0);
      ram_exp_q.delete();
      repeat (15) @(posedge clock);
      #1;
      check("late_ack_ram_write", 32'(ram_write), 32'd0);
      check("late_ack_buffer_empty", 32'(buffer_empty), 32'd1);
      ram_delay_fixed = 0;
      do_write(32'h708, 32'h7000_0003, lat);
      check("post_reset_write_latency", 32'(lat), 32'd1);
      wait_empty("drain_post_reset");

      // Random mix over a small address pool to exercise hits, misses and stalls
      for (int i = 0; i < 250; i++) begin
         logic [31:0] ra;
         ra = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         if ($urandom_range(0, 9) < 5)
            do_write(ra, $urandom, lat);
         else
            do_read(ra, rc, lat);
      end
      wait_empty("drain_random");
      repeat (3) @(posedge clock);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("ram_writes_drained", 32'(ram_exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
